// File: rtl/br_lite_router_mc_pkg.sv
// Shared types for the BrLite multi-local broadcast router.
// Flit layout, service codes, port indices and the CAM line record.
package br_lite_router_mc_pkg;

    typedef enum logic [1:0] {
        SvcAll   = 2'd0,
        SvcTgt   = 2'd1,
        SvcClear = 2'd2
    } br_svc_t;

    typedef logic [3:0] br_port_t;

    // Default 5-port mesh numbering; LOCAL is always the last port.
    localparam br_port_t PortEast  = 4'd0;
    localparam br_port_t PortWest  = 4'd1;
    localparam br_port_t PortNorth = 4'd2;
    localparam br_port_t PortSouth = 4'd3;
    localparam br_port_t PortLocal = 4'd4;

    typedef struct packed {
        br_svc_t     service;
        logic [15:0] source;
        logic [15:0] target;
        logic [7:0]  id;
    } br_data_t;

    typedef struct packed {
        br_data_t    data;
        br_port_t    origin;
        logic        used;
        logic        pending;
        logic        is_local;
        logic [31:0] deadline;
    } br_cam_line_t;

    function automatic br_port_t br_local_port(input int unsigned nport);
        return br_port_t'(nport - 1);
    endfunction

    // Wrap-aware: true once now has reached or passed dl (half-range window).
    function automatic logic br_deadline_reached(input logic [31:0] now, input logic [31:0] dl);
        logic [31:0] diff;
        diff = now - dl;
        return ~diff[31];
    endfunction

endpackage

// File: rtl/br_lite_router_mc_if.sv
// Flit req/ack bus of one router: input side (in_*) and output side (out_*).
// slave modport = router view, master modport = neighbour/bench view.
interface br_lite_router_mc_if #(
    parameter int unsigned NPORT = 5
);
    import br_lite_router_mc_pkg::*;

    br_data_t [NPORT-1:0] in_flit;
    logic     [NPORT-1:0] in_req;
    logic     [NPORT-1:0] in_ack;
    br_data_t [NPORT-1:0] out_flit;
    logic     [NPORT-1:0] out_req;
    logic     [NPORT-1:0] out_ack;

    modport slave  (input in_flit, input in_req, output in_ack,
                    output out_flit, output out_req, input out_ack);
    modport master (output in_flit, output in_req, input in_ack,
                    input out_flit, input out_req, output out_ack);
endinterface

// File: rtl/br_lite_router_mc_rr_arbiter.sv
// Round-robin picker: first set bit of req_i strictly after last_i (wrapping).
// Ports: req_i request vector, last_i last served index, grant_o index, found_o any set.
module br_lite_router_mc_rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [IdxW-1:0] grant_o,
    output logic            found_o
);
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            int unsigned idx;
            idx = (32'(last_i) + off) % N;
            if (!found_o && req_i[IdxW'(idx)]) begin
                found_o = 1'b1;
                grant_o = IdxW'(idx);
            end
        end
    end
endmodule

// File: rtl/br_lite_router_mc.sv
// BrLite broadcast router with CAM duplicate suppression and up to MAX_LOCAL
// outstanding local entries, each turning into a CLEAR at its own deadline.
// Ports: clk_i, rst_ni (async active-low), tick_cnt_i free-running ticks,
//   bus_io flit req/ack bus (slave), local_busy_o, drop_o / timeout_o pulses,
//   cam_used_o valid line count. With BR_STATS_EN defined: stat_drop_o,
//   stat_timeout_o, stat_fwd_o saturating counters.
module br_lite_router_mc
    import br_lite_router_mc_pkg::*;
#(
    parameter logic [15:0] ADDRESS     = 16'h0000,
    parameter int unsigned NPORT       = 5,
    parameter int unsigned CAM_SIZE    = 8,
    parameter int unsigned MAX_LOCAL   = 2,
    parameter int unsigned CLEAR_TICKS = 180,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [31:0]                   tick_cnt_i,
    br_lite_router_mc_if.slave            bus_io,
    output logic                          local_busy_o,
    output logic                          drop_o,
    output logic                          timeout_o,
`ifdef BR_STATS_EN
    output logic [15:0]                   stat_drop_o,
    output logic [15:0]                   stat_timeout_o,
    output logic [15:0]                   stat_fwd_o,
`endif
    output logic [$clog2(CAM_SIZE+1)-1:0] cam_used_o
);
    localparam int unsigned PortW = $clog2(NPORT);
    localparam int unsigned LineW = $clog2(CAM_SIZE);
    localparam int unsigned UsedW = $clog2(CAM_SIZE + 1);
    localparam logic [PortW-1:0] LocalIdx = PortW'(NPORT - 1);

    typedef enum logic [2:0] {InInit, InArb, InTest, InWrite, InClear, InAck} in_state_e;
    typedef enum logic [2:0] {OutInit, OutArb, OutSvc, OutProp, OutAckAll, OutClear,
                              OutLocal, OutAckLocal} out_state_e;

    in_state_e    in_state_q, in_state_d;
    out_state_e   out_state_q, out_state_d;
    br_cam_line_t cam_q [CAM_SIZE];
    br_cam_line_t cam_d [CAM_SIZE];
    logic [PortW-1:0] in_sel_q, in_sel_d, in_last_q, in_last_d;
    logic [LineW-1:0] in_idx_q, in_idx_d, out_line_q, out_line_d, out_last_q, out_last_d;
    logic [NPORT-1:0] in_ack_q, in_ack_d, out_req_q, out_req_d, acked_q, acked_d;
    logic [31:0]      to_cnt_q, to_cnt_d;
    logic             drop_q, drop_d, timeout_q, timeout_d, local_busy_q;
    logic [UsedW-1:0] used_cnt_q, used_sum, local_sum;

    br_data_t         cur_flit;
    br_cam_line_t     cur_line;
    logic             hit, free_found, sweep_found, done;
    logic [LineW-1:0] hit_idx, free_idx, sweep_idx;
    logic [CAM_SIZE-1:0] pend_vec;
    logic [NPORT-1:0] mask;
    logic [PortW-1:0] in_grant;
    logic [LineW-1:0] out_grant;
    logic             in_found, out_found;
`ifdef BR_STATS_EN
    logic             fwd_d;
`endif

    assign cur_flit = bus_io.in_flit[in_sel_q];
    assign cur_line = cam_q[out_line_q];

    br_lite_router_mc_rr_arbiter #(.N(NPORT)) u_in_arb (
        .req_i(bus_io.in_req), .last_i(in_last_q), .grant_o(in_grant), .found_o(in_found)
    );
    br_lite_router_mc_rr_arbiter #(.N(CAM_SIZE)) u_out_arb (
        .req_i(pend_vec), .last_i(out_last_q), .grant_o(out_grant), .found_o(out_found)
    );

    // CAM lookup, free slot, pending vector, deadline sweep candidate, counts.
    always_comb begin
        hit = 1'b0; hit_idx = '0; free_found = 1'b0; free_idx = '0;
        sweep_found = 1'b0; sweep_idx = '0; pend_vec = '0; used_sum = '0; local_sum = '0;
        for (int i = 0; i < CAM_SIZE; i++) begin
            if (!hit && cam_q[i].used && cam_q[i].data.source == cur_flit.source &&
                cam_q[i].data.id == cur_flit.id) begin
                hit = 1'b1; hit_idx = LineW'(i);
            end
            if (!free_found && !cam_q[i].used) begin
                free_found = 1'b1; free_idx = LineW'(i);
            end
            if (!sweep_found && cam_q[i].used && cam_q[i].is_local && !cam_q[i].pending &&
                cam_q[i].data.service != SvcClear &&
                br_deadline_reached(tick_cnt_i, cam_q[i].deadline)) begin
                sweep_found = 1'b1; sweep_idx = LineW'(i);
            end
            pend_vec[i] = cam_q[i].used & cam_q[i].pending;
            used_sum    = used_sum + UsedW'(cam_q[i].used);
            local_sum   = local_sum + UsedW'(cam_q[i].is_local);
        end
    end

    // Output FSM, then sweep, then input FSM: later writers win on cam_d.
    always_comb begin
        cam_d = cam_q;
        in_state_d = in_state_q; in_sel_d = in_sel_q; in_last_d = in_last_q;
        in_idx_d = in_idx_q; in_ack_d = in_ack_q; drop_d = 1'b0;
        out_state_d = out_state_q; out_line_d = out_line_q; out_last_d = out_last_q;
        out_req_d = out_req_q; acked_d = acked_q; to_cnt_d = to_cnt_q; timeout_d = 1'b0;
        mask = '0; done = 1'b0;
`ifdef BR_STATS_EN
        fwd_d = 1'b0;
`endif
        unique case (out_state_q)
            OutInit: if (|pend_vec) out_state_d = OutArb;
            OutArb: begin
                if (out_found) begin
                    out_line_d = out_grant; out_last_d = out_grant; out_state_d = OutSvc;
                end else begin
                    out_state_d = OutInit;
                end
            end
            OutSvc: begin
                if (cur_line.data.service == SvcTgt && cur_line.data.target == ADDRESS) begin
                    out_state_d = OutLocal;
                end else begin
                    out_state_d = OutProp;
                end
            end
            OutProp: begin
                mask = '1;
                mask[cur_line.origin[PortW-1:0]] = 1'b0;
                // LOCAL only sees broadcasts that originated elsewhere.
                if (!(cur_line.data.service == SvcAll && cur_line.data.source != ADDRESS)) begin
                    mask[LocalIdx] = 1'b0;
                end
                out_req_d = mask; acked_d = ~mask; to_cnt_d = '0; out_state_d = OutAckAll;
            end
            OutAckAll: begin
                out_req_d = out_req_q & ~bus_io.out_ack;
                acked_d   = acked_q | bus_io.out_ack;
                if (&acked_d) begin
                    done = 1'b1;
`ifdef BR_STATS_EN
                    fwd_d = 1'b1;
`endif
                end else if (ACK_TIMEOUT != 0 && to_cnt_q == ACK_TIMEOUT - 1) begin
                    out_req_d = '0; timeout_d = 1'b1; done = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
                if (done) begin
                    cam_d[out_line_q].pending = 1'b0;
                    out_state_d = (cur_line.data.service == SvcClear) ? OutClear : OutInit;
                end
            end
            OutClear: begin
                cam_d[out_line_q].used = 1'b0;
                cam_d[out_line_q].is_local = 1'b0;
                out_state_d = OutInit;
            end
            OutLocal: begin
                out_req_d[LocalIdx] = 1'b1;
                if (bus_io.out_ack[LocalIdx]) out_state_d = OutAckLocal;
            end
            OutAckLocal: begin
                out_req_d[LocalIdx] = 1'b0;
                if (!bus_io.out_ack[LocalIdx]) begin
                    cam_d[out_line_q].pending = 1'b0;
                    out_state_d = OutInit;
`ifdef BR_STATS_EN
                    fwd_d = 1'b1;
`endif
                end
            end
            default: out_state_d = OutInit;
        endcase

        if (in_state_q == InInit && out_state_q == OutInit && sweep_found) begin
            cam_d[sweep_idx].data.service = SvcClear;
            cam_d[sweep_idx].pending = 1'b1;
        end

        unique case (in_state_q)
            InInit: if (|bus_io.in_req) in_state_d = InArb;
            InArb: begin
                if (in_found) begin
                    in_sel_d = in_grant; in_last_d = in_grant; in_state_d = InTest;
                end else begin
                    in_state_d = InInit;
                end
            end
            InTest: begin
                if ((cur_flit.service == SvcAll || cur_flit.service == SvcTgt) && !hit) begin
                    if (in_sel_q == LocalIdx && local_busy_q) begin
                        in_state_d = InInit;  // no ack: the local source retries later
                    end else if (free_found) begin
                        in_idx_d = free_idx; in_state_d = InWrite;
                    end else begin
                        drop_d = 1'b1; in_state_d = InAck;
                    end
                end else if (cur_flit.service == SvcClear && hit) begin
                    in_idx_d = hit_idx; in_state_d = InClear;
                end else begin
                    in_state_d = InAck;
                end
            end
            InWrite: begin
                cam_d[in_idx_q].data     = cur_flit;
                cam_d[in_idx_q].origin   = br_port_t'(in_sel_q);
                cam_d[in_idx_q].used     = 1'b1;
                cam_d[in_idx_q].pending  = 1'b1;
                cam_d[in_idx_q].is_local = (in_sel_q == LocalIdx);
                if (in_sel_q == LocalIdx) cam_d[in_idx_q].deadline = tick_cnt_i + CLEAR_TICKS;
                in_state_d = InAck;
            end
            InClear: begin
                if (cam_q[in_idx_q].used && !cam_q[in_idx_q].pending &&
                    cam_q[in_idx_q].data.service != SvcClear) begin
                    cam_d[in_idx_q].data.service = SvcClear;
                    cam_d[in_idx_q].pending = 1'b1;
                end
                in_state_d = InAck;
            end
            InAck: begin
                if (bus_io.in_req[in_sel_q]) begin
                    in_ack_d[in_sel_q] = 1'b1;
                end else begin
                    in_ack_d = '0; in_state_d = InInit;
                end
            end
            default: in_state_d = InInit;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_state_q <= InInit;   out_state_q <= OutInit;
            for (int i = 0; i < CAM_SIZE; i++) cam_q[i] <= '0;
            in_sel_q <= '0;         in_last_q <= LocalIdx;   in_idx_q <= '0;
            out_line_q <= '0;       out_last_q <= '0;
            in_ack_q <= '0;         out_req_q <= '0;         acked_q <= '0;
            to_cnt_q <= '0;         drop_q <= 1'b0;          timeout_q <= 1'b0;
            local_busy_q <= 1'b0;   used_cnt_q <= '0;
        end else begin
            in_state_q <= in_state_d; out_state_q <= out_state_d;
            cam_q <= cam_d;
            in_sel_q <= in_sel_d;     in_last_q <= in_last_d;  in_idx_q <= in_idx_d;
            out_line_q <= out_line_d; out_last_q <= out_last_d;
            in_ack_q <= in_ack_d;     out_req_q <= out_req_d;  acked_q <= acked_d;
            to_cnt_q <= to_cnt_d;     drop_q <= drop_d;        timeout_q <= timeout_d;
            local_busy_q <= (32'(local_sum) >= MAX_LOCAL);
            used_cnt_q <= used_sum;
        end
    end

    assign bus_io.in_ack  = in_ack_q;
    assign bus_io.out_req = out_req_q;
    for (genvar p = 0; p < NPORT; p++) begin : g_flit
        assign bus_io.out_flit[p] = cur_line.data;
    end
    assign local_busy_o = local_busy_q;
    assign drop_o       = drop_q;
    assign timeout_o    = timeout_q;
    assign cam_used_o   = used_cnt_q;

`ifdef BR_STATS_EN
    logic [15:0] st_drop_q, st_to_q, st_fwd_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_drop_q <= '0; st_to_q <= '0; st_fwd_q <= '0;
        end else begin
            if (drop_d && st_drop_q != 16'hFFFF) st_drop_q <= st_drop_q + 16'd1;
            if (timeout_d && st_to_q != 16'hFFFF) st_to_q <= st_to_q + 16'd1;
            if (fwd_d && st_fwd_q != 16'hFFFF) st_fwd_q <= st_fwd_q + 16'd1;
        end
    end
    assign stat_drop_o    = st_drop_q;
    assign stat_timeout_o = st_to_q;
    assign stat_fwd_o     = st_fwd_q;
`endif
endmodule

// File: tb/tb_br_lite_router_mc.sv
// Directed bench for br_lite_router_mc at node 0x0101, CAM_SIZE=2, ACK_TIMEOUT=8.
module tb_br_lite_router_mc;
    import br_lite_router_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] tick = 32'hFFFF_FE70;  // wraps shortly before the local deadlines
    logic        local_busy, drop, tmo;
    logic [1:0]  cam_used;
    logic [4:0]  ack_mask = 5'b11111;
`ifdef BR_STATS_EN
    logic [15:0] st_drop, st_to, st_fwd;
`endif

    br_lite_router_mc_if #(.NPORT(5)) bus ();

    br_lite_router_mc #(
        .ADDRESS(16'h0101), .NPORT(5), .CAM_SIZE(2), .MAX_LOCAL(2),
        .CLEAR_TICKS(180), .ACK_TIMEOUT(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tick_cnt_i(tick), .bus_io(bus),
        .local_busy_o(local_busy), .drop_o(drop), .timeout_o(tmo),
`ifdef BR_STATS_EN
        .stat_drop_o(st_drop), .stat_timeout_o(st_to), .stat_fwd_o(st_fwd),
`endif
        .cam_used_o(cam_used)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 32'd1;
    // Neighbours acknowledge one cycle after seeing a request, unless masked.
    always @(posedge clk) bus.out_ack <= bus.out_req & ack_mask;

    int          n_vec = 0, n_fail = 0;
    int          cyc = 0, rise_cyc = 0, to_cyc = 0, drop_seen = 0, to_seen = 0;
    logic [4:0]  seen_req, prev_req = '0, to_req;
    logic [23:0] seen_flit;

    typedef struct {
        int         port;
        br_data_t   flit;
        logic [4:0] exp_req;
        logic [1:0] exp_used;
    } vec_t;
    vec_t vecs [8];

    function automatic br_data_t mk(br_svc_t s, logic [15:0] src, logic [15:0] tgt,
                                    logic [7:0] id);
        br_data_t f;
        f.service = s; f.source = src; f.target = tgt; f.id = id;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        seen_req |= bus.out_req;
        if (bus.out_req != 0) seen_flit = {bus.out_flit[0].source, bus.out_flit[0].id};
        if (bus.out_req != 0 && prev_req == 0) rise_cyc = cyc;
        prev_req = bus.out_req;
        if (drop) drop_seen++;
        if (tmo) begin
            to_seen++; to_cyc = cyc; to_req = bus.out_req;
        end
    endtask

    task automatic clr_mon();
        seen_req = '0; seen_flit = '0; drop_seen = 0; to_seen = 0; to_req = '1;
    endtask

    task automatic send(input int p, input br_data_t f, input int bound, output bit acked);
        bus.in_flit[p] = f;
        bus.in_req[p]  = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < bound && !acked; i++) begin
            step();
            if (bus.in_ack[p]) acked = 1'b1;
        end
        bus.in_req[p] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.in_ack[p]) break;
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acked;
        bit went;

        vecs[0] = '{0, mk(SvcAll,   16'h0000, 16'h0000, 8'd3), 5'b11110, 2'd1};
        vecs[1] = '{0, mk(SvcAll,   16'h0000, 16'h0000, 8'd3), 5'b00000, 2'd1};
        vecs[2] = '{0, mk(SvcClear, 16'h0000, 16'h0000, 8'd3), 5'b01110, 2'd0};
        vecs[3] = '{1, mk(SvcTgt,   16'h0202, 16'h0101, 8'd5), 5'b10000, 2'd1};
        vecs[4] = '{1, mk(SvcClear, 16'h0202, 16'h0101, 8'd5), 5'b01101, 2'd0};
        vecs[5] = '{2, mk(SvcTgt,   16'h0202, 16'h0303, 8'd6), 5'b01011, 2'd1};
        vecs[6] = '{2, mk(SvcClear, 16'h0202, 16'h0303, 8'd6), 5'b01011, 2'd0};
        vecs[7] = '{3, mk(SvcClear, 16'h0404, 16'h0000, 8'd1), 5'b00000, 2'd0};

        bus.in_flit = '0;
        bus.in_req  = '0;
        clr_mon();
        settle(3);
        chk("rst_req_o", 32'(bus.out_req), 0);
        chk("rst_ack_o", 32'(bus.in_ack), 0);
        chk("rst_drop", 32'(drop), 0);
        chk("rst_timeout", 32'(tmo), 0);
        chk("rst_local_busy", 32'(local_busy), 0);
        chk("rst_cam_used", 32'(cam_used), 0);
        rst_ni = 1'b1;
        settle(2);

        for (int v = 0; v < 8; v++) begin
            clr_mon();
            send(vecs[v].port, vecs[v].flit, 40, acked);
            settle(30);
            chk($sformatf("vec%0d_ack", v), 32'(acked), 1);
            chk($sformatf("vec%0d_req_o", v), 32'(seen_req), 32'(vecs[v].exp_req));
            chk($sformatf("vec%0d_cam_used", v), 32'(cam_used), 32'(vecs[v].exp_used));
            chk($sformatf("vec%0d_drop", v), 32'(drop_seen), 0);
            if (vecs[v].exp_req != 0)
                chk($sformatf("vec%0d_flit", v), 32'(seen_flit),
                    32'({vecs[v].flit.source, vecs[v].flit.id}));
        end

        // Two local entries fill the local budget; a third is held off.
        clr_mon();
        send(4, mk(SvcAll, 16'h0101, 16'h0000, 8'd10), 40, acked);
        settle(15);
        chk("local1_ack", 32'(acked), 1);
        chk("local1_req_o", 32'(seen_req), 32'(5'b01111));
        send(4, mk(SvcAll, 16'h0101, 16'h0000, 8'd11), 40, acked);
        settle(3);
        chk("local2_ack", 32'(acked), 1);
        chk("local2_busy", 32'(local_busy), 1);
        chk("local2_cam_used", 32'(cam_used), 2);
        send(4, mk(SvcAll, 16'h0101, 16'h0000, 8'd12), 20, acked);
        chk("local3_no_ack", 32'(acked), 0);
        settle(80);
        chk("local_before_deadline", 32'(cam_used), 2);
        clr_mon();
        went = 1'b0;
        for (int i = 0; i < 250 && !went; i++) begin
            step();
            if (cam_used == 0) went = 1'b1;
        end
        settle(2);
        chk("local_cleared", 32'(went), 1);
        chk("local_clear_req_o", 32'(seen_req), 32'(5'b01111));
        chk("local_busy_after", 32'(local_busy), 0);
        chk("local_cam_used_after", 32'(cam_used), 0);

        // NORTH never answers: every propagation times out.
        ack_mask = 5'b11011;
        for (int k = 1; k <= 2; k++) begin
            clr_mon();
            send(0, mk(SvcAll, 16'h0202, 16'h0000, 8'(k)), 40, acked);
            settle(25);
            chk($sformatf("to%0d_req_o", k), 32'(seen_req), 32'(5'b11110));
            chk($sformatf("to%0d_pulses", k), 32'(to_seen), 1);
            chk($sformatf("to%0d_delay", k), 32'(to_cyc - rise_cyc), 8);
            chk($sformatf("to%0d_req_at_to", k), 32'(to_req), 0);
            chk($sformatf("to%0d_req_idle", k), 32'(bus.out_req), 0);
        end
        chk("full_cam_used", 32'(cam_used), 2);
        clr_mon();
        send(0, mk(SvcAll, 16'h0202, 16'h0000, 8'd3), 40, acked);
        settle(10);
        chk("full_ack", 32'(acked), 1);
        chk("full_drop_pulse", 32'(drop_seen), 1);
        chk("full_cam_used_after", 32'(cam_used), 2);
        chk("full_no_req", 32'(seen_req), 0);

        // Reset while a CLEAR is waiting in ACK_ALL.
        bus.in_flit[0] = mk(SvcClear, 16'h0202, 16'h0000, 8'd1);
        bus.in_req[0]  = 1'b1;
        went = 1'b0;
        for (int i = 0; i < 40 && !went; i++) begin
            step();
            if (bus.in_ack[0]) bus.in_req[0] = 1'b0;
            if (bus.out_req != 0) went = 1'b1;
        end
        chk("mid_prop_started", 32'(went), 1);
        step();
        chk("mid_cam_used_pre", 32'(cam_used), 2);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req_o", 32'(bus.out_req), 0);
        chk("mid_rst_ack_o", 32'(bus.in_ack), 0);
        chk("mid_rst_timeout", 32'(tmo), 0);
        chk("mid_rst_drop", 32'(drop), 0);
        chk("mid_rst_cam_used", 32'(cam_used), 0);
        bus.in_req = '0;
        settle(2);
        rst_ni = 1'b1;
        settle(3);
        chk("post_rst_cam_used", 32'(cam_used), 0);
        chk("post_rst_req_o", 32'(bus.out_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/br_lite_router_mc.md
Name: br_lite_router_mc

Overview:
- Next-generation BrLite broadcast router for the mesh control network.
- Forwards broadcast (ALL), targeted (TGT) and CLEAR flits over an NPORT req/ack interface, with CAM-based duplicate suppression.
- Generalises the single-outstanding-local design: up to MAX_LOCAL concurrent locally originated entries, each with its own clear deadline.
- Adds an output ack timeout and a CAM-full drop report; one instance per mesh node.

Parameters:
- ADDRESS, 0: 16-bit node address (x[15:8], y[7:0]).
- NPORT, 5: port count; LOCAL is index NPORT-1.
- CAM_SIZE, 8: CAM depth, at least 2.
- MAX_LOCAL, 2: maximum outstanding locally injected entries, 1..CAM_SIZE.
- CLEAR_TICKS, 180: ticks after a local write before that entry turns into a CLEAR.
- ACK_TIMEOUT, 64: cycles the output side waits in ACK_ALL; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- tick_cnt_i  in  32  free-running tick counter
- local_busy_o  out  1  high when MAX_LOCAL local entries are outstanding
- flit_i  in  NPORT x br_data_t  input flits
- req_i  in  NPORT  input requests
- ack_o  out  NPORT  input acks
- flit_o  out  NPORT x br_data_t  selected CAM flit, same value on all ports
- req_o  out  NPORT  output requests
- ack_i  in  NPORT  output acks
- drop_o  out  1  one-cycle pulse: write refused because the CAM is full
- timeout_o  out  1  one-cycle pulse: ACK_ALL abandoned
- cam_used_o  out  $clog2(CAM_SIZE+1)  number of valid CAM lines

Behaviour:
- Reset (asynchronous, rst_ni, clk_i): all req_o/ack_o 0; drop_o, timeout_o, local_busy_o 0; cam_used_o 0; every CAM line used=0, pending=0; both FSMs in INIT; round-robin pointers point at LOCAL / index 0.
- Input FSM: IN_INIT -> IN_ARB when any req_i is set.
  - IN_ARB: round-robin pick starting after the last served port.
  - IN_TEST, write case: taken for service ALL/TGT when source+id is not in the CAM.
    - With a free line -> IN_WRITE.
    - CAM full -> drop_o pulse, then IN_ACK; the flit is consumed and lost.
  - IN_TEST, local over limit: a LOCAL-port request while local_busy_o is high is not acked; return to IN_INIT and retry later.
  - IN_TEST, clear case: CLEAR whose source+id is in the CAM -> IN_CLEAR.
  - IN_TEST, otherwise -> IN_ACK.
  - IN_WRITE: fill the lowest free line (data, origin, used=1, pending=1). When origin is LOCAL, also set local=1 and deadline=tick_cnt_i+CLEAR_TICKS (32-bit wrap-aware compare). Then IN_ACK.
  - IN_CLEAR: when the matched line is not already CLEAR and not pending, set service=CLEAR and pending=1. Then IN_ACK.
  - IN_ACK: hold ack_o[sel]=1 until req_i[sel]=0, then clear it and go to IN_INIT.
- Output FSM: OUT_INIT -> OUT_ARB when any line is used && pending.
  - OUT_ARB: round-robin pick over pending lines.
  - OUT_SVC: TGT with target==ADDRESS -> OUT_LOCAL; otherwise -> OUT_PROP.
  - OUT_PROP: req_o=1 on all ports except origin. LOCAL is included only for ALL with source!=ADDRESS. Then OUT_ACK_ALL.
  - OUT_ACK_ALL: each ack_i drops its req_o bit and marks the port acked.
    - All ports acked -> pending=0; a CLEAR line goes to OUT_CLEAR (used=0, local=0), others go to OUT_INIT.
    - Timeout counter reaching ACK_TIMEOUT: clear req_o, pulse timeout_o, then treat as all acked.
  - OUT_LOCAL: raise req_o[LOCAL]; wait for ack_i[LOCAL] -> OUT_ACK_LOCAL.
  - OUT_ACK_LOCAL: drop req_o[LOCAL]; when ack_i[LOCAL]=0, pending=0 -> OUT_INIT.
- Deadline sweep (every cycle): a line with local && !pending && service!=CLEAR && deadline reached, and both FSMs in INIT, becomes service=CLEAR, pending=1. Lowest index first, one line per cycle.
- Simultaneous events:
  - Output clear of line k and input write to line k in the same cycle cannot happen, because free_index excludes used lines.
  - Input CLEAR and the deadline sweep on the same line in the same cycle: the input path wins; the result is identical.
- cam_used_o is a registered popcount with one-cycle latency.
- local_busy_o is a registered count of local lines >= MAX_LOCAL.

Optional Feature:
- BR_STATS_EN
  - Defined: adds outputs stat_drop_o[15:0], stat_timeout_o[15:0], stat_fwd_o[15:0]. These are saturating counters of drops, timeouts, and completed OUT_ACK_ALL/OUT_ACK_LOCAL, reset to 0.
  - Undefined: the ports and counters are absent.

Decomposition:
- Shared package BrLitePkg: br_data_t, br_svc_t (ALL, TGT, CLEAR), br_port_t, the LOCAL constant, and new br_cam_line_t (data, origin, used, pending, local, deadline).
- One natural sub-module: br_rr_arbiter (parametrised N; req vector, last pointer -> grant index, found). Instantiated twice, once over ports and once over pending lines.

Test Plan:
- ALL from EAST at router 0x0101: source 0x0000, id 3.
  - req_o=11110 (all ports except EAST, LOCAL included), ack_o[EAST] pulses, cam_used_o=1.
  - Repeating the same flit -> acked, no new req_o.
- TGT target=0x0101 from WEST: only req_o[LOCAL] rises; pending cleared after the ack_i[LOCAL] 1->0 handshake.
- Local clear timing:
  - Inject 2 local ALLs with MAX_LOCAL=2 -> local_busy_o=1; a third local req gets no ack.
  - After 181 ticks both lines become CLEAR, propagate, and free -> cam_used_o=0, local_busy_o=0.
- CAM full: CAM_SIZE=2 holding 2 pending lines (ack_i held 0), a third distinct ALL -> drop_o pulse, ack_o still given, cam_used_o stays 2.
- Ack timeout: ACK_TIMEOUT=8, ack_i[NORTH] never asserted -> timeout_o pulses 8 cycles after ACK_ALL entry, req_o=0, pending=0.
- Mid-propagation reset: deassert rst_ni in OUT_ACK_ALL -> all outputs 0 immediately, cam_used_o=0 after release.
